// File: rtl/flag_ctrl.sv
// NVZ condition-flag owner: per-opcode flag-write masks, branch condition evaluation and
// EX->ID flag-hazard handling (ID stall + HOLD by default, forwarding when FLAG_FWD_EN is defined).
module flag_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_flush,
    input  logic [3:0]       ex_opcode,
    input  logic [2:0]       ex_flags,
    input  logic             id_branch,
    input  logic             id_flush,
    input  logic [2:0]       id_ccc,
    output logic             N_flag,
    output logic             V_flag,
    output logic             Z_flag,
    output logic             stall_id,
    output logic             br_valid,
    output logic             br_taken,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned FLG_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLL = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA = 4'b0101;
    localparam logic [OP_W-1:0] OP_ROR = 4'b0110;

    localparam logic [FLG_W-1:0] MASK_NVZ  = 3'b111;
    localparam logic [FLG_W-1:0] MASK_Z    = 3'b001;
    localparam logic [FLG_W-1:0] MASK_NONE = 3'b000;
    localparam logic [2:0]       CCC_UN    = 3'b111;

    // Flags written by each opcode, in {N,V,Z} bit order
    function automatic logic [FLG_W-1:0] wr_mask(input logic [OP_W-1:0] op);
        logic [FLG_W-1:0] m;
        case (op)
            OP_ADD, OP_SUB:                 m = MASK_NVZ;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = MASK_Z;
            default:                        m = MASK_NONE;
        endcase
        return m;
    endfunction

    // Branch condition on a {N,V,Z} flag vector
    function automatic logic cond_eval(input logic [2:0] ccc, input logic [FLG_W-1:0] f);
        logic n;
        logic v;
        logic z;
        logic c;
        n = f[2];
        v = f[1];
        z = f[0];
        case (ccc)
            3'b000:  c = !z;
            3'b001:  c = z;
            3'b010:  c = !z && !n;
            3'b011:  c = n;
            3'b100:  c = z || !n;
            3'b101:  c = n || z;
            3'b110:  c = v;
            default: c = 1'b1;
        endcase
        return c;
    endfunction

    logic [FLG_W-1:0] flags_q;
    logic [FLG_W-1:0] mask_c;
    logic [FLG_W-1:0] flags_next_c;
    logic             commit_c;
    logic             writer_c;
    logic             br_live_c;

    assign mask_c       = wr_mask(ex_opcode);
    assign commit_c     = ex_valid && !ex_stall && !ex_flush;
    assign writer_c     = ex_valid && !ex_flush && (mask_c != MASK_NONE);
    assign flags_next_c = (flags_q & ~mask_c) | (ex_flags & mask_c);
    assign br_live_c    = id_branch && !id_flush;

    // Architectural flag register; unmasked bits hold
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (commit_c) begin
            flags_q <= flags_next_c;
        end
    end

    assign N_flag = flags_q[2];
    assign V_flag = flags_q[1];
    assign Z_flag = flags_q[0];

`ifdef FLAG_FWD_EN

    logic [FLG_W-1:0] flags_fwd_c;

    // Uncommitted EX flags overlay the register whenever EX is producing them
    assign flags_fwd_c = (writer_c && !ex_stall) ? flags_next_c : flags_q;

    always_comb begin
        stall_id = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        if (!rst) begin
            br_valid = br_live_c;
            br_taken = br_live_c && cond_eval(id_ccc, flags_fwd_c);
        end
    end

    assign stall_cnt = '0;

`else

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   hazard_c;

    assign hazard_c = br_live_c && writer_c && (id_ccc != CCC_UN);

    // Next state and same-cycle branch/stall outputs
    always_comb begin
        state_d  = state_q;
        stall_id = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (hazard_c) begin
                        stall_id = 1'b1;
                        if (commit_c) begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        br_valid = br_live_c;
                        br_taken = br_live_c && cond_eval(id_ccc, flags_q);
                    end
                end
                ST_HOLD: begin
                    // Held branch resolves on the just-committed flags; no re-stall
                    br_valid = br_live_c;
                    br_taken = br_live_c && cond_eval(id_ccc, flags_q);
                    state_d  = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (stall_id && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

`endif

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl: spec-level model checked every cycle plus hand-computed literals.
module tb_flag_ctrl;

    localparam int unsigned TB_CNT_W = 2;
    localparam int unsigned CNT_MAX  = 3;
`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XOR_ = 4'h2, SLL = 4'h4;
    localparam logic [3:0] SRA = 4'h5, ROR = 4'h6, PADDSB = 4'hA;

    logic                clk = 1'b0;
    logic                rst;
    logic                ex_valid, ex_stall, ex_flush;
    logic [3:0]          ex_opcode;
    logic [2:0]          ex_flags;
    logic                id_branch, id_flush;
    logic [2:0]          id_ccc;
    logic                N_flag, V_flag, Z_flag;
    logic                stall_id, br_valid, br_taken;
    logic [TB_CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    flag_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .ex_opcode(ex_opcode), .ex_flags(ex_flags),
        .id_branch(id_branch), .id_flush(id_flush), .id_ccc(id_ccc),
        .N_flag(N_flag), .V_flag(V_flag), .Z_flag(Z_flag),
        .stall_id(stall_id), .br_valid(br_valid), .br_taken(br_taken),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_n = 1'b0, m_v = 1'b0, m_z = 1'b0;
    bit m_hold = 1'b0;      // last cycle stalled a branch whose flag producer committed
    int m_cnt = 0;
    bit e_stall = 1'b0;

    function automatic bit cond_true(input logic [2:0] c, input bit n, input bit v, input bit z);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit writes_nvz(input logic [3:0] op);
        return op == ADD || op == SUB;
    endfunction

    function automatic bit writes_z(input logic [3:0] op);
        return writes_nvz(op) || op == XOR_ || op == SLL || op == SRA || op == ROR;
    endfunction

    always @(negedge clk) begin
        if (run) begin
            bit writer, live, fn, fv, fz, e_bv, e_bt;
            writer  = ex_valid && !ex_flush && writes_z(ex_opcode);
            live    = id_branch && !id_flush;
            e_stall = 1'b0;
            e_bv    = 1'b0;
            e_bt    = 1'b0;
            fn = m_n; fv = m_v; fz = m_z;
            if (!rst) begin
                if (FWD) begin
                    if (writer && !ex_stall) begin
                        if (writes_nvz(ex_opcode)) begin
                            fn = ex_flags[2]; fv = ex_flags[1];
                        end
                        fz = ex_flags[0];
                    end
                    e_bv = live;
                end else if (!m_hold && live && writer && id_ccc != 3'b111) begin
                    e_stall = 1'b1;
                end else begin
                    e_bv = live;
                end
                e_bt = e_bv && cond_true(id_ccc, fn, fv, fz);
            end
            chk("N_flag", 32'(N_flag), 32'(m_n));
            chk("V_flag", 32'(V_flag), 32'(m_v));
            chk("Z_flag", 32'(Z_flag), 32'(m_z));
            chk("stall_id", 32'(stall_id), 32'(e_stall));
            chk("br_valid", 32'(br_valid), 32'(e_bv));
            if (e_bv) chk("br_taken", 32'(br_taken), 32'(e_bt));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
    end

    always @(posedge clk) begin
        if (run) begin
            if (rst) begin
                m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
                m_hold = 1'b0;
                m_cnt = 0;
            end else begin
                bit commit;
                commit = ex_valid && !ex_stall && !ex_flush;
                m_hold = e_stall && commit;
                if (e_stall && m_cnt < int'(CNT_MAX)) m_cnt++;
                if (commit && writes_nvz(ex_opcode)) begin
                    m_n = ex_flags[2]; m_v = ex_flags[1];
                end
                if (commit && writes_z(ex_opcode)) m_z = ex_flags[0];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit ev, input bit es, input bit ef, input logic [3:0] op,
                         input logic [2:0] fl, input bit ib, input bit ifl, input logic [2:0] c);
        ex_valid = ev; ex_stall = es; ex_flush = ef; ex_opcode = op; ex_flags = fl;
        id_branch = ib; id_flush = ifl; id_ccc = c;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        nxt();
        run = 1'b1;
        // C0: reset cycle
        @(negedge clk);
        chk("rst_stall", 32'(stall_id), 32'd0);
        chk("rst_bv", 32'(br_valid), 32'd0);
        nxt();
        // C1
        rst = 1'b0;
        @(negedge clk);
        chk("rst_nvz", 32'({N_flag, V_flag, Z_flag}), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        nxt();
        // C2-C4: masks
        drive(1'b1, 1'b0, 1'b0, SUB, 3'b101, 1'b0, 1'b0, 3'b000);
        nxt();
        drive(1'b1, 1'b0, 1'b0, XOR_, 3'b010, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        chk("mask_sub", 32'({N_flag, V_flag, Z_flag}), 32'b101);
        nxt();
        idle();
        @(negedge clk);
        chk("mask_xor", 32'({N_flag, V_flag, Z_flag}), 32'b100);
        nxt();
        // C5-C6: basic hazard, BEQ behind SUB producing Z=1
        drive(1'b1, 1'b0, 1'b0, SUB, 3'b001, 1'b1, 1'b0, 3'b001);
        @(negedge clk);
`ifdef FLAG_FWD_EN
        chk("fwd_stall", 32'(stall_id), 32'd0);
        chk("fwd_bv", 32'(br_valid), 32'd1);
        chk("fwd_bt", 32'(br_taken), 32'd1);
`else
        chk("haz_stall", 32'(stall_id), 32'd1);
        chk("haz_bv0", 32'(br_valid), 32'd0);
`endif
        nxt();
        drive(1'b0, 1'b0, 1'b0, 4'hF, 3'b000, 1'b1, 1'b0, 3'b001);
        @(negedge clk);
        chk("haz_bv1", 32'(br_valid), 32'd1);
        chk("haz_bt1", 32'(br_taken), 32'd1);
`ifndef FLAG_FWD_EN
        chk("haz_cnt1", 32'(stall_cnt), 32'd1);
`endif
        nxt();
        idle();
        nxt();
        // C8-C11: hazard with two ex_stall cycles, SUB clears Z
        drive(1'b1, 1'b1, 1'b0, SUB, 3'b000, 1'b1, 1'b0, 3'b001);
        nxt();
        nxt();
        ex_stall = 1'b0;
        @(negedge clk);
`ifndef FLAG_FWD_EN
        chk("exst_stall3", 32'(stall_id), 32'd1);
        chk("exst_cnt", 32'(stall_cnt), 32'd3);
`endif
        nxt();
        drive(1'b0, 1'b0, 1'b0, 4'hF, 3'b000, 1'b1, 1'b0, 3'b001);
        @(negedge clk);
        chk("exst_bv", 32'(br_valid), 32'd1);
        chk("exst_bt", 32'(br_taken), 32'd0);
        nxt();
        // C12-C13: fifth stall, then flush in HOLD
        drive(1'b1, 1'b0, 1'b0, ADD, 3'b100, 1'b1, 1'b0, 3'b011);
        nxt();
        drive(1'b0, 1'b0, 1'b0, 4'hF, 3'b000, 1'b1, 1'b1, 3'b011);
        @(negedge clk);
        chk("hflush_bv", 32'(br_valid), 32'd0);
        chk("hflush_stall", 32'(stall_id), 32'd0);
`ifndef FLAG_FWD_EN
        chk("sat_cnt", 32'(stall_cnt), 32'd3);
`endif
        nxt();
        // C14: back in RUN, new hazard stalls again
        drive(1'b1, 1'b0, 1'b0, SUB, 3'b000, 1'b1, 1'b0, 3'b011);
        @(negedge clk);
`ifndef FLAG_FWD_EN
        chk("run_again_stall", 32'(stall_id), 32'd1);
`endif
        nxt();
        // C15: flag writer in EX during HOLD does not re-stall
        drive(1'b1, 1'b0, 1'b0, ADD, 3'b100, 1'b1, 1'b0, 3'b011);
        @(negedge clk);
`ifndef FLAG_FWD_EN
        chk("b2b_stall", 32'(stall_id), 32'd0);
        chk("b2b_bt", 32'(br_taken), 32'd0);
`endif
        nxt();
        idle();
        @(negedge clk);
        chk("b2b_n", 32'(N_flag), 32'd1);
        nxt();
        // C17: unconditional branch with ADD in EX
        drive(1'b1, 1'b0, 1'b0, ADD, 3'b000, 1'b1, 1'b0, 3'b111);
        @(negedge clk);
        chk("un_stall", 32'(stall_id), 32'd0);
        chk("un_bt", 32'(br_taken), 32'd1);
        nxt();
        // C18: non-writer opcode with BNE
        drive(1'b1, 1'b0, 1'b0, PADDSB, 3'b111, 1'b1, 1'b0, 3'b000);
        @(negedge clk);
        chk("paddsb_stall", 32'(stall_id), 32'd0);
        chk("paddsb_bt", 32'(br_taken), 32'd1);
        nxt();
        // C19: flushed writer is not a hazard
        drive(1'b1, 1'b0, 1'b1, SUB, 3'b111, 1'b1, 1'b0, 3'b001);
        @(negedge clk);
        chk("exfl_stall", 32'(stall_id), 32'd0);
        chk("exfl_bv", 32'(br_valid), 32'd1);
        chk("exfl_nvz", 32'({N_flag, V_flag, Z_flag}), 32'd0);
        nxt();
        // C20-C23: reset during a stall
        drive(1'b1, 1'b0, 1'b0, XOR_, 3'b001, 1'b0, 1'b0, 3'b000);
        nxt();
        drive(1'b1, 1'b1, 1'b0, SUB, 3'b000, 1'b1, 1'b0, 3'b001);
        @(negedge clk);
        chk("prerst_z", 32'(Z_flag), 32'd1);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stall", 32'(stall_id), 32'd0);
        nxt();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("midrst_nvz", 32'({N_flag, V_flag, Z_flag}), 32'd0);
        chk("midrst_cnt", 32'(stall_cnt), 32'd0);
        nxt();
        // All condition codes over all flag values, checked by the model
        for (int f = 0; f < 8; f++) begin
            drive(1'b1, 1'b0, 1'b0, SUB, 3'(f), 1'b0, 1'b0, 3'b000);
            nxt();
            for (int c = 0; c < 8; c++) begin
                drive(1'b0, 1'b0, 1'b0, 4'hF, 3'b000, 1'b1, 1'b0, 3'(c));
                nxt();
            end
        end
        idle();
        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
